// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands; default is unsigned.
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_prem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic             r_zpend;

   logic             w_accept;
   logic             w_zero;
   logic             w_last;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_prem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   assign w_zero   = (divisor == '0);
   assign w_last   = (r_cnt == '0);
   assign w_accept = start & ~r_busy &
                     ((r_state == S_IDLE) |
                      ((r_state == S_DONE) & ~r_zpend));

   // r_dvd doubles as dividend shifter and quotient accumulator
   assign w_shift    = {r_prem, r_dvd[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_dvs};
   assign w_prem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0]
                                      : w_trial[WIDTH-1:0];
   assign w_q_nxt    = {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};

`ifdef SIGNED_DIV_EN
   logic r_qneg;
   logic r_rneg;

   assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_b_mag = divisor[WIDTH-1] ? -divisor : divisor;
   assign w_q_fin = r_qneg ? -w_q_nxt : w_q_nxt;
   assign w_r_fin = r_rneg ? -w_prem_nxt : w_prem_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
      end else if (w_accept) begin
         r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_rneg <= dividend[WIDTH-1];
      end
   end
`else
   assign w_a_mag = dividend;
   assign w_b_mag = divisor;
   assign w_q_fin = w_q_nxt;
   assign w_r_fin = w_prem_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_zero ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (w_accept)      w_state_nxt = w_zero ? S_DONE : S_CALC;
            else if (!r_zpend) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_prem  <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_zpend <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            // divide-by-zero keeps the raw dividend for the remainder output
            r_dvd   <= w_zero ? dividend : w_a_mag;
            r_dvs   <= w_b_mag;
            r_prem  <= '0;
            r_cnt   <= CW'(WIDTH - 1);
            r_busy  <= ~w_zero;
            r_zpend <= w_zero;
         end else if (r_state == S_CALC) begin
            r_prem <= w_prem_nxt;
            r_dvd  <= w_q_nxt;
            r_cnt  <= r_cnt - CW'(1);
            if (w_last) begin
               r_quo  <= w_q_fin;
               r_rem  <= w_r_fin;
               r_dbz  <= 1'b0;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
         end else if (r_zpend) begin
            r_quo   <= '1;
            r_rem   <= r_dvd;
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_zpend <= 1'b0;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quo;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: arithmetic reference model plus directed vectors.
// Define SIGNED_DIV_EN to exercise the two's-complement build.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference result straight from the arithmetic definition
   function automatic void ref_div(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] q,
                                   output logic [W-1:0] r,
                                   output logic z);
      int sa;
      int sb;
      z = 1'b0;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
`ifdef SIGNED_DIV_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
         if (sa == -(2 ** (W - 1)) && sb == -1) begin
            q = a;
            r = '0;
         end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
         end
`else
         sa = 0;
         sb = 0;
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   int           m_left;
   logic         m_busy;
   logic         m_done;
   logic [W-1:0] m_q;
   logic [W-1:0] m_r;
   logic         m_z;
   logic [W-1:0] p_q;
   logic [W-1:0] p_r;
   logic         p_z;

   // Cycle-level model: m_left counts edges until the pending result lands
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         m_left = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_z    = 1'b0;
      end else if (m_left != 0) begin
         m_left = m_left - 1;
         m_done = (m_left == 0);
         if (m_done) begin
            m_q    = p_q;
            m_r    = p_r;
            m_z    = p_z;
            m_busy = 1'b0;
         end
      end else begin
         m_done = 1'b0;
         if (start === 1'b1) begin
            ref_div(dividend, divisor, p_q, p_r, p_z);
            m_left = (divisor == '0) ? 1 : W;
            m_busy = (divisor != '0);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("quotient", 32'(quotient), 32'(m_q));
         chk("remainder", 32'(remainder), 32'(m_r));
         chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int lat, output int bcnt);
      lat  = n0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 24) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: actual=0 required=1 at %0t", $time);
      end
   endtask

   task automatic run(input string nm, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] eq,
                      input logic [W-1:0] er, input logic ez,
                      input int elat);
      int lat;
      int bc;
      start_op(a, b);
      wait_done(0, lat, bc);
      chk({nm, "_q"}, 32'(quotient), 32'(eq));
      chk({nm, "_r"}, 32'(remainder), 32'(er));
      chk({nm, "_z"}, 32'(div_by_zero), 32'(ez));
      chk({nm, "_lat"}, 32'(lat), 32'(elat));
   endtask

   logic [W-1:0] vec_a [6] = '{8'd0, 8'd1, 8'd254, 8'd128, 8'd9, 8'd0};
   logic [W-1:0] vec_b [6] = '{8'd5, 8'd1, 8'd17, 8'd255, 8'd10, 8'd0};

   initial begin
      int lat;
      int bc;
      int nd;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_z", 32'(div_by_zero), 32'd0);

`ifdef SIGNED_DIV_EN
      run("s_m7d2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, W);
      run("s_ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W);
      run("s_7dm2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, W);
      run("s_13d0", 8'd13, 8'd0, 8'hFF, 8'd13, 1'b1, 1);
      run("s_100d7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W);
`else
      start_op(8'd100, 8'd7);
      wait_done(0, lat, bc);
      chk("u100_q", 32'(quotient), 32'd14);
      chk("u100_r", 32'(remainder), 32'd2);
      chk("u100_z", 32'(div_by_zero), 32'd0);
      chk("u100_lat", 32'(lat), 32'd8);
      chk("u100_busy", 32'(bc), 32'd8);

      run("u255d1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W);
      run("u255d255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, W);

      start_op(8'd13, 8'd0);
      wait_done(0, lat, bc);
      chk("u13d0_q", 32'(quotient), 32'hFF);
      chk("u13d0_r", 32'(remainder), 32'd13);
      chk("u13d0_z", 32'(div_by_zero), 32'd1);
      chk("u13d0_lat", 32'(lat), 32'd1);
      chk("u13d0_busy", 32'(bc), 32'd0);

      start_op(8'd200, 8'd3);
      repeat (4) @(negedge clk);
      start_op(8'd9, 8'd9);
      wait_done(5, lat, bc);
      chk("ign_q", 32'(quotient), 32'd66);
      chk("ign_r", 32'(remainder), 32'd2);
      chk("ign_lat", 32'(lat), 32'd8);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("ign_no_done", 32'(nd), 32'd0);

      start_op(8'd200, 8'd3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_q", 32'(quotient), 32'd0);
      chk("mrst_r", 32'(remainder), 32'd0);
      chk("mrst_z", 32'(div_by_zero), 32'd0);
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("mrst_no_done", 32'(nd), 32'd0);
      run("u50d5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, W);
`endif

      for (int i = 0; i < 6; i++) begin
         start_op(vec_a[i], vec_b[i]);
         wait_done(0, lat, bc);
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
